// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package inst_fetch_pkg;

  localparam int RegW         = 32;
  localparam int IF2IDBusSize = 2 * RegW;
  localparam int JbrBusW      = RegW + 1;

  localparam logic [RegW-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_WAIT    = ST_WAIT,
    S_DISCARD = ST_DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [RegW-1:0] pc;
    logic [RegW-1:0] inst;
  } if2id_t;

  function automatic logic [RegW-1:0] pc_advance(input logic [RegW-1:0] pc,
                                                 input logic [RegW-1:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-side bus bundle: instruction SRAM request/response and the if_id handoff.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic            mem_start_o;
  logic            mem_rw_o;
  logic [23:0]     mem_addr_o;
  logic [RegW-1:0] mem_data_i;
  logic            mem_r_ready_i;
  logic            mem_busy_i;
  logic            if_valid_o;
  logic [RegW-1:0] if_pc_o;
  logic [RegW-1:0] if_inst_o;
  logic            id_ready_i;

  modport master (
    output mem_start_o, mem_rw_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o,
    input  mem_data_i, mem_r_ready_i, mem_busy_i, id_ready_i
  );

  modport slave (
    input  mem_start_o, mem_rw_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o,
    output mem_data_i, mem_r_ready_i, mem_busy_i, id_ready_i
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, inst} pairs; flush empties it in one cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (cnt != {(AW+1){1'b0}});
  assign do_push = push && ((cnt != CAP) || do_pop);

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      cnt    <= {(AW+1){1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == {(AW+1){1'b0}});
  assign full  = (cnt == CAP);
  assign count = cnt;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues one SRAM read at a time,
// buffers returned words for ID and squashes everything on a jump/branch redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [RegW-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              IBUF_DEPTH = 4,
  parameter logic [RegW-1:0] PC_STEP    = 32'd4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [JbrBusW-1:0] jbr_bus_i,
  inst_fetch_if.master       bus
);

  localparam int CW = $clog2(IBUF_DEPTH) + 1;
  localparam logic [CW-1:0] FIFO_CAP = CW'(IBUF_DEPTH);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [RegW-1:0] fetch_pc;
  logic [RegW-1:0] fetch_pc_adv;
  logic [RegW-1:0] fetch_pc_d;
  logic [RegW-1:0] req_pc;
  logic [RegW-1:0] target;
  logic            redirect;
  logic            start;
  logic            push;
  logic            pop;
  logic            if_valid;
  logic            fifo_empty;
  logic            fifo_full;
  logic [CW-1:0]   fifo_count;
  if2id_t          head;
  if2id_t          push_entry;

  assign redirect   = jbr_bus_i[JbrBusW-1];
  assign target     = jbr_bus_i[RegW-1:0];
  assign push_entry = {req_pc, bus.mem_data_i};
  assign fetch_pc_d = redirect ? target : fetch_pc_adv;

  // FSM state, fetch PC and the address of the request in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_d;
      if (start) req_pc <= fetch_pc;
    end
  end

  // Next state, request pulse and push; a start reserves a FIFO slot, so the full
  // check on push only matters if that invariant is ever broken.
  always_comb begin
    state_next   = state;
    fetch_pc_adv = fetch_pc;
    start        = 1'b0;
    push         = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rst_i && !redirect && !bus.mem_busy_i && (fifo_count < FIFO_CAP)) begin
          start      = 1'b1;
          state_next = S_WAIT;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.mem_r_ready_i && !redirect && !fifo_full) begin
          push         = 1'b1;
          fetch_pc_adv = pc_advance(req_pc, PC_STEP);
          state_next   = S_IDLE;
        end else if (bus.mem_r_ready_i) begin
          state_next = S_IDLE;
        end else if (redirect) begin
          state_next = S_DISCARD;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_DISCARD: begin
        if (bus.mem_r_ready_i) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_DISCARD;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  fetch_fifo #(
    .WIDTH (IF2IDBusSize),
    .DEPTH (IBUF_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (push_entry),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign if_valid = !fifo_empty && !redirect;
  assign pop      = if_valid && bus.id_ready_i;

  assign bus.mem_start_o = start;
  assign bus.mem_rw_o    = 1'b1;
  assign bus.mem_addr_o  = (state == S_IDLE) ? fetch_pc[23:0] : req_pc[23:0];
  assign bus.if_valid_o  = if_valid;
  assign bus.if_pc_o     = fifo_empty ? {RegW{1'b0}} : head.pc;
  assign bus.if_inst_o   = fifo_empty ? {RegW{1'b0}} : head.inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a fixed-latency instruction memory model.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int LAT = 3;

  typedef struct {
    logic [23:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [32:0] jbr;

  inst_fetch_if bus();

  inst_fetch #(
    .RESET_PC   (32'h8000_0000),
    .IBUF_DEPTH (4),
    .PC_STEP    (32'd4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .jbr_bus_i (jbr),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic        obs_start;
  logic        obs_valid;
  logic [23:0] obs_addr;
  logic [31:0] obs_pc;
  logic [31:0] obs_inst;
  logic [23:0] starts[$];
  logic [63:0] pops[$];
  bit          mem_en;
  bit          pending;
  int          cnt;
  logic [23:0] paddr;
  vec_t        tbl[5];

  function automatic logic [31:0] model_word(input logic [23:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [63:0] pop_at(input int k);
    if (k < pops.size()) return pops[k];
    return 64'hxxxx_xxxx_xxxx_xxxx;
  endfunction

  function automatic logic [23:0] start_at(input int k);
    if (k < starts.size()) return starts[k];
    return 24'hxx_xxxx;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge and drive the memory model's response.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.mem_r_ready_i = 1'b0;
    bus.mem_data_i    = 32'h0;
    if (mem_en && pending) begin
      if (cnt > 1) cnt--;
      else begin
        bus.mem_r_ready_i = 1'b1;
        bus.mem_data_i    = model_word(paddr);
        pending           = 1'b0;
      end
    end
  endtask

  // Sample settled outputs for the current cycle and log starts/pops.
  task automatic look();
    #1;
    obs_start = bus.mem_start_o;
    obs_addr  = bus.mem_addr_o;
    obs_valid = bus.if_valid_o;
    obs_pc    = bus.if_pc_o;
    obs_inst  = bus.if_inst_o;
    if (obs_start === 1'b1) begin
      starts.push_back(obs_addr);
      if (mem_en) begin
        pending = 1'b1;
        cnt     = LAT;
        paddr   = obs_addr;
      end
    end
    if (obs_valid === 1'b1 && bus.id_ready_i === 1'b1) pops.push_back({obs_pc, obs_inst});
  endtask

  task automatic cyc();
    tick();
    look();
  endtask

  task automatic hold_reset(input logic idr);
    tick();
    rst = 1'b1;
    jbr = 33'h0;
    bus.mem_busy_i    = 1'b0;
    bus.id_ready_i    = idr;
    bus.mem_r_ready_i = 1'b0;
    pending = 1'b0;
    mem_en  = 1'b1;
    look();
    tick();
    look();
    starts.delete();
    pops.delete();
  endtask

  task automatic release_reset();
    tick();
    rst = 1'b0;
    look();
  endtask

  task automatic wait_start(input string name, input logic [23:0] addr, input int bound);
    bit found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      cyc();
      if (obs_start === 1'b1 && obs_addr === addr) begin
        found = 1'b1;
        break;
      end
    end
    chk(name, 64'(found), 64'd1);
  endtask

  task automatic wait_pops(input string name, input int n, input int bound);
    for (int i = 0; i < bound && pops.size() < n; i++) cyc();
    chk(name, 64'(pops.size() >= n), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vcount;
    int ns;
    int np;
    rst = 1'b1;
    jbr = 33'h0;
    bus.mem_data_i    = 32'h0;
    bus.mem_r_ready_i = 1'b0;
    bus.mem_busy_i    = 1'b0;
    bus.id_ready_i    = 1'b0;

    tbl[0] = '{24'h000000, 32'h8000_0000, 32'hC0DE_0000};
    tbl[1] = '{24'h000004, 32'h8000_0004, 32'hC0DE_0004};
    tbl[2] = '{24'h000008, 32'h8000_0008, 32'hC0DE_0008};
    tbl[3] = '{24'h00000C, 32'h8000_000C, 32'hC0DE_000C};
    tbl[4] = '{24'h000010, 32'h8000_0010, 32'hC0DE_0010};

    // Reset state, then in-order fetch with ID always ready.
    hold_reset(1'b1);
    chk("rst_start", 64'(obs_start), 64'd0);
    chk("rst_addr",  64'(obs_addr),  64'h000000);
    chk("rst_valid", 64'(obs_valid), 64'd0);
    chk("rst_pc",    64'(obs_pc),    64'h0);
    chk("rst_inst",  64'(obs_inst),  64'h0);
    release_reset();
    chk("t1_first_start", 64'(obs_start), 64'd1);
    chk("t1_first_addr",  64'(obs_addr),  64'h000000);
    vcount = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (obs_valid === 1'b1) vcount++;
      if (i == 3) chk("t1_no_valid_c3", 64'(obs_valid), 64'd0);
      if (i == 4) chk("t1_valid_c4",    64'(obs_valid), 64'd1);
    end
    chk("t1_valid_cycles", 64'(vcount), 64'd3);
    chk("t1_start_count",  64'(starts.size()), 64'd4);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t1_addr%0d", k), 64'(start_at(k)), 64'(tbl[k].exp_addr));
      chk($sformatf("t1_pop%0d", k), pop_at(k), {tbl[k].exp_pc, tbl[k].exp_inst});
    end

    // Back-pressure: FIFO fills to 4, then drains in order and fetch resumes.
    hold_reset(1'b0);
    release_reset();
    for (int i = 1; i <= 19; i++) cyc();
    chk("t2_start_count", 64'(starts.size()), 64'd4);
    chk("t2_no_pops",     64'(pops.size()),   64'd0);
    chk("t2_head_valid",  64'(obs_valid),     64'd1);
    chk("t2_head_pc",     64'(obs_pc),        64'h8000_0000);
    tick();
    bus.id_ready_i = 1'b1;
    look();
    chk("t2_no_start_on_full_pop", 64'(obs_start), 64'd0);
    for (int i = 0; i < 9; i++) cyc();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_addr%0d", k), 64'(start_at(k)), 64'(tbl[k].exp_addr));
      chk($sformatf("t2_pop%0d", k), pop_at(k), {tbl[k].exp_pc, tbl[k].exp_inst});
    end

    // Redirect while waiting for 0x80000008: returning word is dropped.
    hold_reset(1'b1);
    release_reset();
    wait_start("t3_wait08", 24'h000008, 20);
    tick();
    jbr = {1'b1, 32'h8000_1000};
    look();
    chk("t3_redir_valid", 64'(obs_valid), 64'd0);
    chk("t3_redir_start", 64'(obs_start), 64'd0);
    tick();
    jbr = 33'h0;
    look();
    chk("t3_empty_after", 64'(obs_valid), 64'd0);
    ns = starts.size();
    np = pops.size();
    wait_start("t3_target_start", 24'h001000, 12);
    chk("t3_single_start", 64'(starts.size()), 64'(ns + 1));
    chk("t3_no_pop",       64'(pops.size()),   64'(np));
    wait_pops("t3_pop_wait", np + 1, 12);
    chk("t3_first_pop", pop_at(np), {32'h8000_1000, 32'hC0DE_1000});

    // Redirect coinciding with r_ready and a pop while two entries are buffered.
    hold_reset(1'b0);
    release_reset();
    wait_start("t4_wait08", 24'h000008, 20);
    cyc();
    cyc();
    tick();
    bus.id_ready_i = 1'b1;
    jbr = {1'b1, 32'h8000_2000};
    look();
    chk("t4_redir_valid", 64'(obs_valid), 64'd0);
    chk("t4_redir_start", 64'(obs_start), 64'd0);
    chk("t4_no_pop",      64'(pops.size()), 64'd0);
    tick();
    jbr = 33'h0;
    look();
    chk("t4_flushed",     64'(obs_valid), 64'd0);
    chk("t4_target_start", 64'(obs_start), 64'd1);
    chk("t4_target_addr",  64'(obs_addr),  64'h002000);
    wait_pops("t4_pop_wait", 1, 12);
    chk("t4_first_pop", pop_at(0), {32'h8000_2000, 32'hC0DE_2000});

    // Controller busy in IDLE holds off the next start at the held fetch PC.
    hold_reset(1'b1);
    release_reset();
    cyc();
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.mem_busy_i = 1'b1;
      look();
      chk($sformatf("t5_busy_nostart%0d", i), 64'(obs_start), 64'd0);
    end
    chk("t5_held_addr", 64'(obs_addr), 64'h000004);
    tick();
    bus.mem_busy_i = 1'b0;
    look();
    chk("t5_start_after_busy", 64'(obs_start), 64'd1);
    chk("t5_start_addr",       64'(obs_addr),  64'h000004);

    // Reset during WAIT, then a stale r_ready in IDLE is ignored.
    hold_reset(1'b1);
    mem_en = 1'b0;
    release_reset();
    cyc();
    tick();
    rst = 1'b1;
    look();
    tick();
    rst = 1'b0;
    bus.mem_busy_i    = 1'b1;
    bus.mem_r_ready_i = 1'b1;
    bus.mem_data_i    = 32'hDEAD_BEEF;
    look();
    chk("t6_busy_nostart", 64'(obs_start), 64'd0);
    chk("t6_reset_addr",   64'(obs_addr),  64'h000000);
    tick();
    bus.mem_busy_i = 1'b0;
    mem_en = 1'b1;
    look();
    chk("t6_stale_ignored", 64'(obs_valid), 64'd0);
    chk("t6_restart",       64'(obs_start), 64'd1);
    chk("t6_restart_addr",  64'(obs_addr),  64'h000000);
    wait_pops("t6_pop_wait", 1, 12);
    chk("t6_first_pop", pop_at(0), {32'h8000_0000, 32'hC0DE_0000});

    // Redirect in IDLE beats start; PC wraps at 32 bits.
    hold_reset(1'b1);
    tick();
    rst = 1'b0;
    jbr = {1'b1, 32'hFFFF_FFFC};
    look();
    chk("t7_redir_nostart", 64'(obs_start), 64'd0);
    tick();
    jbr = 33'h0;
    look();
    chk("t7_start",      64'(obs_start), 64'd1);
    chk("t7_start_addr", 64'(obs_addr),  64'hFFFFFC);
    wait_pops("t7_pop_wait", 2, 20);
    chk("t7_pop0", pop_at(0), {32'hFFFF_FFFC, 32'hC0DE_FFFC});
    chk("t7_pop1", pop_at(1), {32'h0000_0000, 32'hC0DE_0000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
